// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-requester ALU arbiter: op codes, the
// illegal-op boundary and the arbiter FSM encoding.
package alu_arbiter_pkg;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_XOR = 4'b0100;
    localparam logic [3:0] OP_LUI = 4'b0101;
    localparam logic [3:0] OP_SRL = 4'b0110;
    localparam logic [3:0] OP_SLL = 4'b0111;

    // First op code outside the legal range
    localparam logic [3:0] OP_ILLEGAL_MIN = 4'b1000;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    function automatic logic op_is_legal(input logic [3:0] op);
        return op < OP_ILLEGAL_MIN;
    endfunction

endpackage

// File: rtl/alu_arbiter_rr_picker.sv
// Combinational two-way round-robin winner; last_grant names the requester
// that won most recently, so a tie goes to the other one.
module alu_rr_picker (
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    output logic valid,
    output logic winner
);

    assign valid  = req0 | req1;
    assign winner = (req0 & req1) ? ~last_grant : req1;

endmodule

// File: rtl/alu_arbiter.sv
// Arbitrates two requesters onto one shared combinational ALU; one operation
// at a time through IDLE -> EXEC -> DONE.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0_i,
    input  logic                  req1_i,
    input  logic [3:0]            op0_i,
    input  logic [3:0]            op1_i,
    input  logic [DATA_WIDTH-1:0] a0_i,
    input  logic [DATA_WIDTH-1:0] b0_i,
    input  logic [DATA_WIDTH-1:0] a1_i,
    input  logic [DATA_WIDTH-1:0] b1_i,
    output logic                  gnt0_o,
    output logic                  gnt1_o,
    output logic                  rvalid0_o,
    output logic                  rvalid1_o,
    output logic [DATA_WIDTH-1:0] result_o,
    output logic                  err_o,
    output logic                  busy_o,
    output logic [3:0]            alu_op_o,
    output logic [DATA_WIDTH-1:0] alu_a_o,
    output logic [DATA_WIDTH-1:0] alu_b_o,
    input  logic [DATA_WIDTH-1:0] alu_result_i
);

    state_t                state, state_nxt;
    logic                  win_valid, winner, last_grant;
    logic [3:0]            op_sel, op_q;
    logic [DATA_WIDTH-1:0] a_sel, b_sel, a_q, b_q;
    logic                  illegal_q;

    alu_rr_picker u_picker (
        .req0       (req0_i),
        .req1       (req1_i),
        .last_grant (last_grant),
        .valid      (win_valid),
        .winner     (winner)
    );

    assign op_sel = winner ? op1_i : op0_i;
    assign a_sel  = winner ? a1_i  : a0_i;
    assign b_sel  = winner ? b1_i  : b0_i;

    always_ff @(posedge clk) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (win_valid) state_nxt = S_EXEC;
            S_EXEC:  state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            gnt0_o     <= 1'b0;
            gnt1_o     <= 1'b0;
            rvalid0_o  <= 1'b0;
            rvalid1_o  <= 1'b0;
            err_o      <= 1'b0;
            result_o   <= '0;
            op_q       <= OP_ADD;
            a_q        <= '0;
            b_q        <= '0;
            illegal_q  <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            gnt0_o    <= 1'b0;
            gnt1_o    <= 1'b0;
            rvalid0_o <= 1'b0;
            rvalid1_o <= 1'b0;
            err_o     <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (win_valid) begin
                        gnt0_o     <= ~winner;
                        gnt1_o     <= winner;
                        last_grant <= winner;
                        // Illegal ops run as ADD on the ALU but are flagged at DONE
                        illegal_q  <= ~op_is_legal(op_sel);
                        op_q       <= op_is_legal(op_sel) ? op_sel : OP_ADD;
                        a_q        <= a_sel;
                        b_q        <= b_sel;
                    end
                end
                S_EXEC: begin
                    result_o  <= alu_result_i;
                    rvalid0_o <= gnt0_o;
                    rvalid1_o <= gnt1_o;
                    err_o     <= illegal_q;
                end
                default: ;
            endcase
        end
    end

    assign busy_o   = (state != S_IDLE);
    assign alu_op_o = (state == S_EXEC) ? op_q : OP_ADD;
    assign alu_a_o  = (state == S_EXEC) ? a_q  : '0;
    assign alu_b_o  = (state == S_EXEC) ? b_q  : '0;

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32, operand/result width.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-low reset.
REQ-004 req0_i / req1_i  input  1 each  requester k asks for one ALU operation.
REQ-005 op0_i / op1_i  input  4 each  requested ALU operation code.
REQ-006 a0_i, b0_i / a1_i, b1_i  input  DATA_WIDTH each  operands of requester k.
REQ-007 gnt0_o / gnt1_o  output  1 each  one-cycle grant; operands captured.
REQ-008 rvalid0_o / rvalid1_o  output  1 each  one-cycle result-valid to the granted requester.
REQ-009 result_o  output  DATA_WIDTH  last captured ALU result, shared by both requesters.
REQ-010 err_o  output  1  illegal op code flag, coincident with rvalid.
REQ-011 busy_o  output  1  high whenever state is not IDLE.
REQ-012 alu_op_o  output  4  operation code driven to the shared ALU.
REQ-013 alu_a_o, alu_b_o  output  DATA_WIDTH each  operands driven to the shared ALU.
REQ-014 alu_result_i  input  DATA_WIDTH  combinational result returned by the shared ALU.

Function
REQ-015 FSM states IDLE, EXEC, DONE; one operation per 3 cycles max throughput.
REQ-016 IDLE: no req -> stay IDLE; any req -> EXEC, winner's op/a/b latched into internal registers at that edge.
REQ-017 Arbitration: single requester wins; both requesting -> requester not granted last time wins; last_grant resets to 1 (requester 0 wins first tie).
REQ-018 gntk_o is registered, high exactly during the EXEC cycle for the winner, never both high.
REQ-019 Requester holds req/op/a/b stable until it sees gnt high, deasserts req at the edge ending EXEC; req still high in following IDLE counts as a new request.
REQ-020 EXEC: alu_op_o/alu_a_o/alu_b_o driven from latched registers only; EXEC -> DONE unconditionally, result_o <= alu_result_i at that edge.
REQ-021 DONE: rvalidk_o high one cycle for the winner; DONE -> IDLE unconditionally; new requests ignored in DONE.
REQ-022 result_o holds its value until the next EXEC->DONE edge.
REQ-023 Legal op codes 0000..0111 (ADD, SUB, AND, OR, XOR, LUI, SRL, SLL); op >= 1000 latched as illegal: alu_op_o forced 0000, result captured normally, err_o high in DONE with rvalid.
REQ-024 Outside EXEC: alu_op_o = 0000, alu_a_o = 0, alu_b_o = 0.
REQ-025 Latency: req sampled at edge N -> gnt during cycle N..N+1 -> rvalid/result valid during cycle N+1..N+2.
REQ-026 Requester-0-only stream: granted on every IDLE, no starvation check needed; alternating ties strictly alternate grants.

Reset
REQ-027 reset low at an edge: state IDLE, gnt/rvalid/err/busy 0, result_o 0, latched regs 0, last_grant 1.
REQ-028 Reset in EXEC or DONE aborts the operation; no rvalid issued for it; requester must re-request.

Structure
REQ-029 Shared package holds 4-bit ALU op code constants (ADD 0000 .. SLL 0111), the illegal-op boundary, and FSM state encoding; the ALU control decoder uses the same op constants.
REQ-030 One sub-module alu_rr_picker: combinational two-way round-robin winner from req0, req1, last_grant.

Verification
REQ-031 Bench instantiates the real ALU on the alu_* ports; req0 op 0000 a=5 b=3 -> gnt0 next cycle, rvalid0 two cycles after req sample, result_o = 8, err_o 0.
REQ-032 req0 and req1 same cycle (op0 0001 a=10 b=4; op1 0010 a=0xF0 b=0x3C) after reset -> gnt0 first, result 6; req1 held -> gnt1 next IDLE, result 0x30.
REQ-033 Both requesters continuously requesting for 12 cycles -> grants alternate 0,1,0,1, one grant per 3 cycles, gnt0 and gnt1 never both high.
REQ-034 req1 op 1010 a=7 b=9 -> alu_op_o 0000 in EXEC, rvalid1 and err_o high together, result_o = 16.
REQ-035 reset asserted during EXEC of req0 op 0000 -> no rvalid0, result_o 0, busy_o 0 next cycle; tie after reset granted to requester 0.
REQ-036 No requests for 5 cycles -> busy_o 0, alu_op_o 0000, alu_a_o/alu_b_o 0, result_o unchanged.
